imem_loader: RTL
================

# imem_loader

- Writer-side companion to the instruction memory: fills it from an 8-bit byte stream before the CPU starts fetching.
- Accepts bytes over a valid/ready handshake and assembles them big-endian into 32-bit instruction words.
- Issues one word write per instruction at byte address `index*4`, which is the same addressing the fetch path uses (`pc/4` selects the word).
- Sits between the host/boot byte source and the instruction memory write port; asserts `done` when the requested program length has been written.

## Interface
- `DEPTH`, 256: number of 32-bit words in instruction memory.
- `ADDR_W`, 8: word-index width, log2(DEPTH).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a load; sampled only in IDLE.
- `word_count`  in  ADDR_W+1: number of words to load; latched on accepted `start`.
- `byte_valid`  in  1: a byte is offered on `byte_data`.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader can take a byte.
- `wr_en`  out  1: instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  32: byte address of the word, `{index, 2'b00}` zero-extended.
- `wr_data`  out  32: assembled instruction word.
- `busy`  out  1: high in LOAD, WRITE and DONE.
- `done`  out  1: one-cycle pulse at the end of a load.
- `err`  out  1: sticky; set when the latched `word_count` > DEPTH; cleared by the next accepted `start`.
- `checksum`  out  8: running byte checksum (see Configuration).

## Operation
- States are IDLE, LOAD, WRITE and DONE.
- IDLE
  - `start`=1 latches `cnt = min(word_count, DEPTH)`, sets `err = (word_count > DEPTH)`, clears index, byte position and checksum.
  - Goes to DONE if `cnt`==0, otherwise to LOAD.
- LOAD
  - `byte_ready`=1. A byte is accepted when `byte_valid && byte_ready`.
  - Byte position 0 goes to bits [31:24], position 1 to [23:16], position 2 to [15:8], position 3 to [7:0].
  - Accepting the byte at position 3 moves to WRITE.
- WRITE
  - One cycle with `wr_en`=1, `byte_ready`=0, `wr_data` = the assembled word, `wr_addr` = `index*4`.
  - Next state is DONE if `index == cnt-1`, otherwise LOAD with `index+1` and byte position 0.
- DONE
  - One cycle with `done`=1, then IDLE.
- `start` is ignored outside IDLE.
- Bytes offered while `byte_ready`=0 are not consumed; the source must hold them.
- `index` never wraps: at most DEPTH words are written, so the maximum `wr_addr` is `4*(DEPTH-1)` = 0x3FC.
- Reset mid-load abandons the partial word with no write; memory contents already written are untouched.

## Timing
- Reset values: `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `checksum`=0; state IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from `byte_valid` to `byte_ready`.
- Best-case throughput is 5 cycles per word: 4 accept cycles plus 1 WRITE cycle.
- `start` to first `byte_ready`=1 is 1 cycle.
- The last WRITE is followed by `done` on the next cycle; `busy` falls the cycle after `done`.
- `start` with `word_count`=0: `done` is high 1 cycle after `start` and no write occurs.
- Stalls: `byte_valid` low in LOAD holds state and byte position indefinitely.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined: `checksum` is the mod-256 sum of every accepted byte since the last accepted `start`. It is updated in the cycle after each accept and stable from DONE until the next `start`.
- Undefined: `checksum` is tied to 0 and no checksum logic is built; all other behaviour is identical.

## Test plan
- **Reset mid-load:** reset after 2 bytes of word 0, then check outputs.
  - Expected: no `wr_en` pulse, and every output equals its reset value.
- **Single word:** `word_count`=1, bytes 0x8C,0x01,0x00,0x04.
  - Expected: one `wr_en` pulse with `wr_addr`=0x0, `wr_data`=0x8C010004, then a `done` pulse.
  - With the macro: `checksum`=0x91.
- **Back-to-back with stalls:** `word_count`=3, `byte_valid` deasserted for 2 cycles mid-word 1.
  - Expected: writes at 0x0, 0x4, 0x8 carry the correct words.
  - Expected: no byte is lost or duplicated, and `done` fires exactly once.
- **Zero and overflow:** `word_count`=0, then a separate load with `word_count`=300.
  - `word_count`=0: `done` one cycle after `start`, no write, `err`=0.
  - `word_count`=300: exactly 256 writes, last `wr_addr`=0x3FC, `err`=1 until the next `start`.
- **Start while busy:** pulse `start` with `word_count`=5 during an active 2-word load.
  - Expected: the pulse is ignored, exactly 2 writes occur, and the load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory at index*4.
// Optional running byte checksum when IMEM_LOADER_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_INC = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        pos_q, pos_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic              accept;
    logic              last_word;

    // byte_ready depends on state only, so accept never feeds back into ready
    assign accept    = (state_q == S_LOAD) && byte_valid;
    assign last_word = ({1'b0, idx_q} == (cnt_q - ONE_C));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = (word_count > DEPTH_C) ? DEPTH_C : word_count;
                    err_d   = (word_count > DEPTH_C);
                    idx_d   = '0;
                    pos_d   = '0;
                    state_d = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    case (pos_q)
                        2'd0:    word_d[31:24] = byte_data;
                        2'd1:    word_d[23:16] = byte_data;
                        2'd2:    word_d[15:8]  = byte_data;
                        default: word_d[7:0]   = byte_data;
                    endcase
                    pos_d = pos_q + 2'd1;
                    if (pos_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    idx_d   = idx_q + IDX_INC;
                    pos_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign wr_en      = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign wr_data    = word_q;
    assign wr_addr    = {{(32-ADDR_W-2){1'b0}}, idx_q, 2'b00};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE) && start) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
